mc_controller: RTL and testbench

Multicycle control unit for the ARM core: replaces the single-cycle controller when the datapath is rebuilt around one shared instruction/data memory plus IR, ALUOut and Data holding registers. Sequences each instruction through a Moore FSM, holds the NZCV flags register, evaluates the condition field once per instruction and gates all architectural writes. Decode is pure combinational logic on the latched instruction; every enable is a function of state, latched condition and instruction fields.

---
 rtl/mc_controller.sv | 209 ++++++++++++++++++++
 tb/tb_mc_controller.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multicycle ARM control unit.
// A Moore FSM steps each instruction through the shared-memory datapath.
// The unit also holds the NZCV flags register and a condition bit that is
// latched once per instruction, in DECODE. Every architectural write enable
// is gated by that latched condition, so a failed instruction still walks
// its states but changes nothing. PC+4 in FETCH is the one exception.
module mc_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ImmSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [2:0]  ALUControl,
    output logic [1:0]  ResultSrc,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } stateType;

    stateType   state;
    logic [3:0] flags;
    logic       condExReg;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic [3:0] unusedRn;

    logic       condHolds;
    logic [2:0] aluDec;
    logic       isCmp;
    logic [1:0] flagW;

    logic       irWrite;
    logic       regW;
    logic       memW;
    logic       branch;
    logic       fetchPc;
    logic       regWriteGated;

    assign cond     = Instr[19:16];
    assign op       = Instr[15:14];
    assign funct    = Instr[13:8];
    assign cmd      = funct[4:1];
    assign rd       = Instr[3:0];
    assign unusedRn = Instr[7:4];

    // Evaluate the condition field against the stored flags (not ALUFlags)
    always_comb begin
        condHolds = 1'b0;
        case (cond)
            4'b0000: condHolds = flags[2];
            4'b0001: condHolds = ~flags[2];
            4'b0010: condHolds = flags[1];
            4'b0011: condHolds = ~flags[1];
            4'b0100: condHolds = flags[3];
            4'b0101: condHolds = ~flags[3];
            4'b0110: condHolds = flags[0];
            4'b0111: condHolds = ~flags[0];
            4'b1000: condHolds = flags[1] & ~flags[2];
            4'b1001: condHolds = ~flags[1] | flags[2];
            4'b1010: condHolds = (flags[3] == flags[0]);
            4'b1011: condHolds = (flags[3] != flags[0]);
            4'b1100: condHolds = ~flags[2] & (flags[3] == flags[0]);
            4'b1101: condHolds = flags[2] | (flags[3] != flags[0]);
            4'b1110: condHolds = 1'b1;
            default: condHolds = 1'b0;
        endcase
    end

    // Map the data-processing cmd to an ALU operation; unknown cmds behave as ADD
    always_comb begin
        aluDec = 3'b000;
        isCmp  = 1'b0;
        case (cmd)
            4'b0100: aluDec = 3'b000;
            4'b0010: aluDec = 3'b001;
            4'b0000: aluDec = 3'b010;
            4'b1100: aluDec = 3'b011;
            4'b1010: begin
                aluDec = 3'b001;
                isCmp  = 1'b1;
            end
            default: aluDec = 3'b000;
        endcase
    end

    assign flagW[1] = funct[0] | isCmp;
    assign flagW[0] = flagW[1] & ((aluDec == 3'b000) | (aluDec == 3'b001));

    // Sequence the FSM, latch the condition in DECODE and update flags at the end of EXECUTE
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            flags     <= 4'b0000;
            condExReg <= 1'b0;
        end else begin
            case (state)
                FETCH:    state <= DECODE;
                DECODE: begin
                    condExReg <= condHolds;
                    case (op)
                        2'b01:   state <= MEMADR;
                        2'b00:   state <= funct[5] ? EXECUTEI : EXECUTER;
                        2'b10:   state <= BRANCH;
                        default: state <= FETCH;
                    endcase
                end
                MEMADR:   state <= funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: state <= FETCH;
                EXECUTER, EXECUTEI: begin
                    state <= ALUWB;
                    if (condExReg) begin
                        if (flagW[1]) flags[3:2] <= ALUFlags[3:2];
                        if (flagW[0]) flags[1:0] <= ALUFlags[1:0];
                    end
                end
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore decode of datapath controls from the current state; raw write requests are gated below
    always_comb begin
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = 3'b000;
        ResultSrc  = 2'b00;
        irWrite    = 1'b0;
        regW       = 1'b0;
        memW       = 1'b0;
        branch     = 1'b0;
        fetchPc    = 1'b0;
        case (state)
            FETCH: begin
                irWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                fetchPc   = 1'b1;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:   ALUSrcB = 2'b01;
            MEMREAD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                regW      = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                memW   = 1'b1;
            end
            EXECUTER: ALUControl = aluDec;
            EXECUTEI: begin
                ALUSrcB    = 2'b01;
                ALUControl = aluDec;
            end
            ALUWB:    regW = ~isCmp;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    assign regWriteGated = regW & condExReg;
    assign RegWrite      = regWriteGated & ~reset;
    assign MemWrite      = memW & condExReg & ~reset;
    assign IRWrite       = irWrite & ~reset;
    assign PCWrite       = ~reset & (fetchPc | (branch & condExReg) |
                                     (regWriteGated & (rd == 4'd15)));

    assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
    assign ImmSrc = op;
    assign State  = state;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller.
// A behavioural model plays the part of the instruction register. For each
// instruction it builds the list of states the instruction must visit, and
// it tracks the flags and the condition outcome. The bench compares every
// DUT output against that model on every cycle. A directed prologue pins the
// model with hand-computed state traces and write counts; randomized
// instructions and resets follow.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc;
    logic [2:0]  ALUControl;
    logic [3:0]  State;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegSrc(RegSrc),
        .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .ResultSrc(ResultSrc), .State(State)
    );

    typedef struct {
        logic [19:0] instr;
        logic [3:0]  alu;
        bit          rst;
        logic [31:0] states;
        int          regw;
        int          memw;
        int          pcw;
        bit          chkF;
        logic [3:0]  flags;
    } dirType;

    dirType      dir[$];
    int          assertions = 0;
    int          failures   = 0;
    int          cycle      = 0;

    logic [3:0]  mState;
    logic [3:0]  mRest[$];
    logic [3:0]  mFlags;
    logic        mCond;
    logic [19:0] mInstr;
    int          curDir   = -1;
    int          dIdx     = 0;
    int          rstCount = 0;
    bit          armed    = 1'b0;

    logic [31:0] trace = 32'h0;
    int          trRegW = 0, trMemW = 0, trPcw = 0, trOwner = -1;

    function automatic logic [19:0] mkDP(input logic [3:0] c, input logic i,
                                         input logic [3:0] cmd, input logic s,
                                         input logic [3:0] rd);
        return {c, 2'b00, i, cmd, s, 4'h2, rd};
    endfunction

    function automatic logic [19:0] mkMem(input logic [3:0] c, input logic l,
                                          input logic [3:0] rd);
        return {c, 2'b01, 5'b11000, l, 4'h5, rd};
    endfunction

    function automatic logic [19:0] mkB(input logic [3:0] c);
        return {c, 2'b10, 6'b000000, 4'hF, 4'h0};
    endfunction

    function automatic logic [19:0] randInstr();
        logic [3:0] c;
        logic [1:0] op;
        logic [3:0] cmd;
        c  = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) c = 4'hE;
        op = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
            0:       cmd = 4'b0100;
            1:       cmd = 4'b0010;
            2:       cmd = 4'b0000;
            3:       cmd = 4'b1100;
            default: cmd = 4'b1010;
        endcase
        return {c, op, 1'($urandom_range(0, 1)), cmd, 1'($urandom_range(0, 1)),
                4'($urandom), 4'($urandom)};
    endfunction

    // Condition codes come in complementary pairs: the low bit inverts the base test
    function automatic logic condHolds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, base;
        n = f[3]; z = f[2]; cf = f[1]; v = f[0];
        case (c[3:1])
            3'd0:    base = z;
            3'd1:    base = cf;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = cf & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        return (c == 4'hF) ? 1'b0 : (base ^ c[0]);
    endfunction

    function automatic logic [2:0] aluFor(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 3'b001;
            4'b0000:          return 3'b010;
            4'b1100:          return 3'b011;
            default:          return 3'b000;
        endcase
    endfunction

    task automatic addDir(input logic [19:0] instr, input logic [3:0] alu, input bit rst,
                          input logic [31:0] states, input int regw, input int memw,
                          input int pcw, input bit chkF, input logic [3:0] flags);
        dirType d;
        d.instr = instr; d.alu = alu; d.rst = rst; d.states = states;
        d.regw = regw; d.memw = memw; d.pcw = pcw; d.chkF = chkF; d.flags = flags;
        dir.push_back(d);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                     name, cycle, actual, expected);
        end
    endtask

    // The states an instruction visits after DECODE, read straight from its opcode
    task automatic buildSeq(input logic [19:0] ins);
        mRest.delete();
        case (ins[15:14])
            2'b01: begin
                mRest.push_back(4'd2);
                if (ins[8]) begin
                    mRest.push_back(4'd3);
                    mRest.push_back(4'd4);
                end else begin
                    mRest.push_back(4'd5);
                end
            end
            2'b00: begin
                mRest.push_back(ins[13] ? 4'd7 : 4'd6);
                mRest.push_back(4'd8);
            end
            2'b10: mRest.push_back(4'd9);
            default: ;
        endcase
    endtask

    task automatic closeTrace();
        if (trOwner >= 0) begin
            checkOutput("dir state trace", trace, dir[trOwner].states);
            checkOutput("dir RegWrite count", 32'(trRegW), 32'(dir[trOwner].regw));
            checkOutput("dir MemWrite count", 32'(trMemW), 32'(dir[trOwner].memw));
            checkOutput("dir PCWrite count", 32'(trPcw), 32'(dir[trOwner].pcw));
            if (dir[trOwner].chkF)
                checkOutput("model flags", 32'(mFlags), 32'(dir[trOwner].flags));
        end
        trOwner = -1;
        trace   = 32'h0;
        trRegW  = 0;
        trMemW  = 0;
        trPcw   = 0;
    endtask

    task automatic applyStimulus();
        if (armed && mState == 4'd3) begin
            rstCount = 2;
            armed    = 1'b0;
        end
        if (curDir < 0 && rstCount == 0 && $urandom_range(0, 199) == 0)
            rstCount = $urandom_range(1, 2);
        reset = (rstCount > 0);
        if (rstCount > 0) rstCount--;
        ALUFlags = (curDir >= 0) ? dir[curDir].alu : 4'($urandom);
        if (mState == 4'd1) Instr = mInstr;
    endtask

    task automatic compareCycle();
        logic [3:0] s;
        logic       isCmp, expRegW, expMemW, expPcw, expIr;
        logic [1:0] expB, expRes;
        s       = mState;
        isCmp   = (Instr[12:9] == 4'b1010);
        expRegW = ((s == 4'd4) || (s == 4'd8 && !isCmp)) && mCond && !reset;
        expMemW = (s == 4'd5) && mCond && !reset;
        expIr   = (s == 4'd0) && !reset;
        expPcw  = !reset && ((s == 4'd0) || (s == 4'd9 && mCond) ||
                             (expRegW && Instr[3:0] == 4'hF));
        checkOutput("State", 32'(State), 32'(s));
        checkOutput("RegWrite", 32'(RegWrite), 32'(expRegW));
        checkOutput("MemWrite", 32'(MemWrite), 32'(expMemW));
        checkOutput("IRWrite", 32'(IRWrite), 32'(expIr));
        checkOutput("PCWrite", 32'(PCWrite), 32'(expPcw));
        if (!reset) begin
            expB   = (s <= 4'd1) ? 2'b10 :
                     (s == 4'd2 || s == 4'd7 || s == 4'd9) ? 2'b01 : 2'b00;
            expRes = (s <= 4'd1 || s == 4'd9) ? 2'b10 : (s == 4'd4) ? 2'b01 : 2'b00;
            checkOutput("AdrSrc", 32'(AdrSrc), 32'(s == 4'd3 || s == 4'd5));
            checkOutput("ALUSrcA", 32'(ALUSrcA), 32'(s <= 4'd1));
            checkOutput("ALUSrcB", 32'(ALUSrcB), 32'(expB));
            checkOutput("ResultSrc", 32'(ResultSrc), 32'(expRes));
            checkOutput("ALUControl", 32'(ALUControl),
                        32'((s == 4'd6 || s == 4'd7) ? aluFor(Instr[12:9]) : 3'b000));
            checkOutput("ImmSrc", 32'(ImmSrc), 32'(Instr[15:14]));
            checkOutput("RegSrc", 32'(RegSrc),
                        32'({Instr[15:14] == 2'b01 && !Instr[8], Instr[15:14] == 2'b10}));
        end
        if (s == 4'd0 && !reset) closeTrace();
        trace = {trace[27:0], State};
        if (RegWrite) trRegW++;
        if (MemWrite) trMemW++;
        if (PCWrite && State != 4'd0) trPcw++;
    endtask

    // Advance the model across the coming clock edge
    task automatic updateModel();
        logic [3:0] cmd;
        logic       fw1, arith;
        if (reset) begin
            mState = 4'd0;
            mRest.delete();
            mFlags = 4'b0000;
            mCond  = 1'b0;
        end else begin
            if (mState == 4'd1) mCond = condHolds(Instr[19:16], mFlags);
            if ((mState == 4'd6 || mState == 4'd7) && mCond) begin
                cmd   = Instr[12:9];
                fw1   = Instr[8] | (cmd == 4'b1010);
                arith = !(cmd == 4'b0000 || cmd == 4'b1100);
                if (fw1) mFlags[3:2] = ALUFlags[3:2];
                if (fw1 && arith) mFlags[1:0] = ALUFlags[1:0];
            end
            if (mState == 4'd0) begin
                if (dIdx < dir.size()) begin
                    curDir = dIdx;
                    mInstr = dir[dIdx].instr;
                    armed  = dir[dIdx].rst;
                    dIdx++;
                end else begin
                    curDir = -1;
                    mInstr = randInstr();
                end
                trOwner = curDir;
                buildSeq(mInstr);
                mState = 4'd1;
            end else if (mRest.size() == 0) begin
                mState = 4'd0;
            end else begin
                mState = mRest.pop_front();
            end
        end
    endtask

    initial begin
        addDir(mkDP(4'hE, 1'b0, 4'b0100, 1'b1, 4'd1),  4'b0110, 0, 32'h0168,  1, 0, 0, 1, 4'b0110);
        addDir(mkDP(4'hE, 1'b1, 4'b1010, 1'b1, 4'd0),  4'b0100, 0, 32'h0178,  0, 0, 0, 1, 4'b0100);
        addDir(mkB(4'h0),                              4'b0000, 0, 32'h019,   0, 0, 1, 0, 4'b0000);
        addDir(mkDP(4'hE, 1'b1, 4'b1010, 1'b1, 4'd0),  4'b0000, 0, 32'h0178,  0, 0, 0, 1, 4'b0000);
        addDir(mkB(4'h0),                              4'b1111, 0, 32'h019,   0, 0, 0, 0, 4'b0000);
        addDir(mkDP(4'hE, 1'b1, 4'b1010, 1'b1, 4'd0),  4'b0100, 0, 32'h0178,  0, 0, 0, 1, 4'b0100);
        addDir(mkMem(4'hE, 1'b1, 4'd4),                4'b0000, 0, 32'h01234, 1, 0, 0, 0, 4'b0000);
        addDir(mkMem(4'hE, 1'b1, 4'd4),                4'b0000, 1, 32'h01230, 0, 0, 0, 1, 4'b0000);
        addDir(mkDP(4'h0, 1'b0, 4'b0100, 1'b0, 4'd2),  4'b0100, 0, 32'h0168,  0, 0, 0, 1, 4'b0000);
        addDir(mkMem(4'hE, 1'b0, 4'd3),                4'b0000, 0, 32'h0125,  0, 1, 0, 0, 4'b0000);
        addDir(mkDP(4'hE, 1'b1, 4'b1010, 1'b1, 4'd0),  4'b0100, 0, 32'h0178,  0, 0, 0, 1, 4'b0100);
        addDir(mkDP(4'h1, 1'b0, 4'b0010, 1'b1, 4'd5),  4'b1011, 0, 32'h0168,  0, 0, 0, 1, 4'b0100);
        addDir(mkB(4'h0),                              4'b0000, 0, 32'h019,   0, 0, 1, 0, 4'b0000);
        addDir(mkDP(4'hE, 1'b1, 4'b0100, 1'b0, 4'd15), 4'b0000, 0, 32'h0178,  1, 0, 1, 0, 4'b0000);
        addDir({4'hE, 2'b11, 14'h0},                   4'b0000, 0, 32'h01,    0, 0, 0, 0, 4'b0000);

        reset    = 1'b1;
        Instr    = 20'h0;
        ALUFlags = 4'h0;
        @(posedge clk);
        mState   = 4'd0;
        mFlags   = 4'b0000;
        mCond    = 1'b0;
        mInstr   = 20'h0;
        rstCount = 1;

        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            cycle = i;
            applyStimulus();
            #1;
            compareCycle();
            updateModel();
        end

        if (dIdx < dir.size())
            checkOutput("directed list consumed", 32'(dIdx), 32'(dir.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
